// File: rtl/ue14500_pkg.sv
// ue14500_pkg: UE14500 opcodes, sequencer states and program-word field offsets
package ue14500_pkg;
  localparam logic [3:0] I_NOP0 = 4'h0;
  localparam logic [3:0] I_LD   = 4'h1;
  localparam logic [3:0] I_ADD  = 4'h2;
  localparam logic [3:0] I_SUB  = 4'h3;
  localparam logic [3:0] I_ONE  = 4'h4;
  localparam logic [3:0] I_NAND = 4'h5;
  localparam logic [3:0] I_OR   = 4'h6;
  localparam logic [3:0] I_XOR  = 4'h7;
  localparam logic [3:0] I_STO  = 4'h8;
  localparam logic [3:0] I_STOC = 4'h9;
  localparam logic [3:0] I_IEN  = 4'hA;
  localparam logic [3:0] I_OEN  = 4'hB;
  localparam logic [3:0] I_JMP  = 4'hC;
  localparam logic [3:0] I_RTN  = 4'hD;
  localparam logic [3:0] I_SKZ  = 4'hE;
  localparam logic [3:0] I_NOPF = 4'hF;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} seq_state_e;
  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 4;
  localparam int OPD_MSB = 3;
  localparam int OPD_LSB = 0;
  localparam int SEL_MSB = 1;
endpackage

// File: rtl/ue14500_retstack.sv
// ue14500_retstack: shift-register return stack with top at entry 0; ports clk, rst_n, push, pop, din, dout, full, empty
module ue14500_retstack #(
  parameter int STACK_DEPTH = 2,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int CW = $clog2(STACK_DEPTH + 1);
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] e [STACK_DEPTH];
  assign full = cnt == CW'(STACK_DEPTH);
  assign empty = cnt == '0;
  assign dout = e[0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (push && !full) cnt <= cnt + CW'(1);
    else if (pop && !empty) cnt <= cnt - CW'(1);
  always_ff @(posedge clk)
    if (push && !full) begin
      e[0] <= din;
      for (int i = 1; i < STACK_DEPTH; i++) e[i] <= e[i-1];
    end else if (pop && !empty) begin
      for (int i = 0; i < STACK_DEPTH - 1; i++) e[i] <= e[i+1];
    end
endmodule

// File: rtl/ue14500_sequencer.sv
// ue14500_sequencer: fetch/issue loop for the UE14500 core (program load, run/stop, JMP/RTN via return stack, sticky err_o); optional step_i with UE14500_SEQ_STEP_EN
module ue14500_sequencer
  import ue14500_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int STACK_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_i,
`ifdef UE14500_SEQ_STEP_EN
  input  logic              step_i,
`endif
  input  logic              load_en_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [7:0]        load_data_i,
  input  logic [3:0]        din_i,
  input  logic              cpu_jmp_i,
  input  logic              cpu_rtn_i,
  output logic [3:0]        instr_o,
  output logic              data_o,
  output logic              issue_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] pc_o
);
  seq_state_e state, state_nxt;
  logic [7:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] pc_nxt, pc_inc, ret_addr;
  logic in_wait, go, jmp, rtn, full, empty, err_set;
`ifdef UE14500_SEQ_STEP_EN
  assign go = run_i || step_i;
`else
  assign go = run_i;
`endif
  assign in_wait = state == S_WAIT;
  assign pc_inc = pc_o + ADDR_W'(1);
  assign jmp = in_wait && cpu_jmp_i;
  assign rtn = in_wait && cpu_rtn_i && !cpu_jmp_i;
  assign err_set = (jmp && (cpu_rtn_i || full)) || (rtn && empty);
  ue14500_retstack #(.STACK_DEPTH(STACK_DEPTH), .ADDR_W(ADDR_W)) u_stack (
    .clk(clk), .rst_n(rst_n), .push(jmp), .pop(rtn), .din(pc_inc),
    .dout(ret_addr), .full(full), .empty(empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == S_IDLE ? (go ? S_ISSUE : S_IDLE) :
                state == S_ISSUE ? S_WAIT : (run_i ? S_ISSUE : S_IDLE);
  always_comb begin
    issue_o = state == S_ISSUE;
    busy_o = state != S_IDLE;
  end
  // pc only moves at the end of WAIT; mem cannot change while busy, so mem[pc_o] is the issued word
  always_comb
    pc_nxt = jmp ? ADDR_W'(mem[pc_o][OPD_MSB:OPD_LSB]) :
             rtn ? (empty ? '0 : ret_addr) :
             in_wait ? pc_inc : pc_o;
  // instr/data are captured on entry to ISSUE so they are stable for the whole ISSUE/WAIT pair
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc_o <= '0;
      err_o <= 1'b0;
      instr_o <= I_NOP0;
      data_o <= 1'b0;
    end else begin
      pc_o <= pc_nxt;
      err_o <= err_o || err_set;
      if (state_nxt == S_ISSUE) begin
        instr_o <= mem[pc_nxt][OP_MSB:OP_LSB];
        data_o <= din_i[mem[pc_nxt][SEL_MSB:OPD_LSB]];
      end
    end
  always_ff @(posedge clk)
    if (load_en_i && state == S_IDLE) mem[load_addr_i] <= load_data_i;
endmodule

// File: tb/tb_ue14500_sequencer.sv
// tb_ue14500_sequencer: scoreboard bench for ue14500_sequencer with a small core model driving JMP/RTN
module tb_ue14500_sequencer;
  import ue14500_pkg::*;
  localparam int AW = 4;
  typedef struct packed {
    logic [3:0]    instr;
    logic          data;
    logic [AW-1:0] pc;
  } exp_t;
  exp_t q[$];
  logic clk = 0, rst_n = 1, run_i = 0, load_en_i = 0;
  logic [AW-1:0] load_addr_i = '0;
  logic [7:0] load_data_i = '0;
  logic [3:0] din_i = 4'b0010;
  logic cpu_jmp_i = 0, cpu_rtn_i = 0;
  logic [3:0] instr_o;
  logic data_o, issue_o, busy_o, err_o;
  logic [AW-1:0] pc_o;
`ifdef UE14500_SEQ_STEP_EN
  logic step_i = 0;
`endif
  logic [7:0] prog [16];
  bit extra_rtn = 0;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  ue14500_sequencer #(.ADDR_W(AW), .STACK_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .run_i(run_i),
`ifdef UE14500_SEQ_STEP_EN
    .step_i(step_i),
`endif
    .load_en_i(load_en_i), .load_addr_i(load_addr_i), .load_data_i(load_data_i),
    .din_i(din_i), .cpu_jmp_i(cpu_jmp_i), .cpu_rtn_i(cpu_rtn_i),
    .instr_o(instr_o), .data_o(data_o), .issue_o(issue_o), .busy_o(busy_o),
    .err_o(err_o), .pc_o(pc_o)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // core model: raise JMP/RTN during WAIT according to the issued opcode
  always @(negedge clk) begin
    cpu_jmp_i = busy_o && !issue_o && instr_o == I_JMP;
    cpu_rtn_i = busy_o && !issue_o && (instr_o == I_RTN || (extra_rtn && instr_o == I_JMP));
  end
  // monitor: every issue pulse must match the next scoreboard entry
  always @(negedge clk)
    if (issue_o === 1'b1) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_issue: got instr %0h pc %0h expected no issue", instr_o, pc_o);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("issue", {27'd0, instr_o, data_o, pc_o}, {27'd0, e});
      end
    end
  task automatic load(input int a, input logic [7:0] d);
    @(negedge clk);
    load_en_i = 1;
    load_addr_i = AW'(a);
    load_data_i = d;
    @(negedge clk);
    load_en_i = 0;
    prog[a] = d;
  endtask
  task automatic expect_pc(input int p);
    exp_t e;
    logic [7:0] w;
    w = prog[p];
    e.instr = w[7:4];
    e.data = din_i[w[1:0]];
    e.pc = AW'(p);
    q.push_back(e);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    run_i = 0;
    @(negedge clk);
    rst_n = 1;
  endtask
  // run exactly k instructions by dropping run_i during the k-th ISSUE
  task automatic run(input int k, input bit lock);
    int seen = 0;
    int cyc = 0;
    @(negedge clk);
    run_i = 1;
    while (seen < k && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (issue_o) begin
        seen++;
        if (seen == k) run_i = 0;
        if (lock && seen == 1) begin
          load_en_i = 1;
          load_addr_i = AW'(1);
          load_data_i = 8'hFF;
        end
      end
    end
    run_i = 0;
    check("issue_count", seen, k);
    cyc = 0;
    while (busy_o && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    load_en_i = 0;
    check("busy_after_run", busy_o, 0);
  endtask
  initial begin
    int cyc;
    #2 rst_n = 0;
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_issue", issue_o, 0);
    check("rst_err", err_o, 0);
    check("rst_pc", pc_o, 0);
    check("rst_instr", instr_o, 0);
    check("rst_data", data_o, 0);
    @(negedge clk);
    rst_n = 1;
    load(0, 8'h40);
    load(1, 8'h11);
    load(2, 8'h80);
    load(3, 8'h00);
    for (int i = 4; i < 16; i++) load(i, 8'h70 | 8'(i));
    repeat (6) @(negedge clk);
    check("idle_busy", busy_o, 0);
    // linear fetch with pc wrap 15 -> 0
    for (int i = 0; i < 18; i++) expect_pc(i % 16);
    run(18, 0);
    check("linear_pc", pc_o, 2);
    check("linear_err", err_o, 0);
    // jump to 9, return to 3
    do_reset();
    load(2, 8'hC9);
    load(9, 8'hD0);
    expect_pc(0); expect_pc(1); expect_pc(2); expect_pc(9); expect_pc(3);
    run(5, 0);
    check("jr_pc", pc_o, 4);
    check("jr_err", err_o, 0);
    // three nested jumps on a depth-2 stack
    do_reset();
    load(0, 8'hC5);
    load(5, 8'hC7);
    load(7, 8'hCA);
    load(10, 8'hD0);
    expect_pc(0); expect_pc(5);
    run(2, 0);
    check("ovf_pc_a", pc_o, 7);
    check("ovf_err_a", err_o, 0);
    expect_pc(7); expect_pc(10);
    run(2, 0);
    check("ovf_pc_b", pc_o, 6);
    check("ovf_err_b", err_o, 1);
    // return with empty stack
    do_reset();
    check("rst_err_clear", err_o, 0);
    load(0, 8'hD0);
    expect_pc(0);
    run(1, 0);
    check("udf_pc", pc_o, 0);
    check("udf_err", err_o, 1);
    // JMP and RTN together: jump wins and pushes
    do_reset();
    load(0, 8'hC6);
    extra_rtn = 1;
    expect_pc(0);
    run(1, 0);
    extra_rtn = 0;
    check("both_pc", pc_o, 6);
    check("both_err", err_o, 1);
    load(6, 8'hD0);
    expect_pc(6);
    run(1, 0);
    check("both_ret_pc", pc_o, 1);
    // stop after one instruction, then load lockout while busy
    do_reset();
    load(0, 8'h40);
    expect_pc(0);
    run(1, 0);
    check("stop_pc", pc_o, 1);
    expect_pc(1); expect_pc(2); expect_pc(9);
    run(3, 1);
    check("lock_pc", pc_o, 3);
    do_reset();
    expect_pc(0); expect_pc(1);
    run(2, 0);
    check("readback_pc", pc_o, 2);
    // reset during WAIT of a jump discards the pending pc update
    expect_pc(2);
    @(negedge clk);
    run_i = 1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(busy_o && !issue_o) && cyc < 10);
    check("reach_wait", busy_o && !issue_o, 1);
    rst_n = 0;
    #1;
    check("mrst_busy", busy_o, 0);
    check("mrst_issue", issue_o, 0);
    check("mrst_pc", pc_o, 0);
    check("mrst_instr", instr_o, 0);
    check("mrst_data", data_o, 0);
    check("mrst_err", err_o, 0);
    run_i = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    check("mrst_pc_after", pc_o, 0);
    check("mrst_busy_after", busy_o, 0);
`ifdef UE14500_SEQ_STEP_EN
    expect_pc(0);
    @(negedge clk);
    step_i = 1;
    @(negedge clk);
    step_i = 0;
    repeat (5) @(negedge clk);
    check("step_pc", pc_o, 1);
    check("step_busy", busy_o, 0);
`endif
    repeat (2) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
